// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, bubble encoding, visible PC offset,
// and instruction field constants used by both fetch and the controller.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  // TST with S=0: decodes as an instruction but writes nothing downstream
  localparam logic [31:0] BUBBLE_WORD = 32'hE100_0000;

  localparam int unsigned PC_OFFSET = 8;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_MVN = 4'hF;

  function automatic logic [3:0] cond_field(input logic [31:0] instr);
    return instr[31:28];
  endfunction

  function automatic logic [3:0] op_field(input logic [31:0] instr);
    return instr[24:21];
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction+PC holding buffer that catches a memory response
// arriving while the downstream stage is stalled.
module fetch_skid_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_pc,
  output logic              full,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] pc
);

  // push beats pop so a same-cycle refill keeps the entry occupied
  always_ff @(posedge CLOCK_50) begin
    if (reset || flush) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      data <= push_data;
      pc   <= push_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency instruction memory and
// presents IR_out/PC_out with a skid buffer for stalls. FETCH_PERF_CNT_EN adds fetch/flush counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [DATA_W-1:0] BUBBLE_WORD = cpu_pkg::BUBBLE_WORD
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] IR_out,
  output logic [ADDR_W-1:0] PC_out,
  output logic              ir_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam logic [ADDR_W-1:0] PC_OFF = ADDR_W'(PC_OFFSET);

  fetch_state_e      state, state_d;
  logic [ADDR_W-1:0] fetch_pc;
  logic              vld_p0;
  logic [ADDR_W-1:0] pc_p0;
  logic [ADDR_W-1:0] pc_vis_p0;
  logic              skid_full, skid_push, skid_pop;
  logic [DATA_W-1:0] skid_data;
  logic [ADDR_W-1:0] skid_pc;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // The skid only drains when stall drops, which is exactly when requests resume,
  // so no separate skid term is needed to keep the next word in order.
  always_comb begin
    state_d  = state;
    imem_req = 1'b0;
    case (state)
      IDLE: state_d = RUN;
      RUN: begin
        imem_req = !reset && !stall && !branch_en;
        if (stall && !branch_en) state_d = HOLD;
      end
      HOLD: begin
        imem_req = !reset && !stall && !branch_en;
        if (!stall || branch_en) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_addr = fetch_pc;
  assign pc_vis_p0 = pc_p0 + PC_OFF;
  assign skid_pop  = !stall && skid_full;
  assign skid_push = vld_p0 && !branch_en && (stall || skid_full);

  fetch_skid_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .push      (skid_push),
    .pop       (skid_pop),
    .flush     (branch_en),
    .push_data (imem_rdata),
    .push_pc   (pc_vis_p0),
    .full      (skid_full),
    .data      (skid_data),
    .pc        (skid_pc)
  );

  // p0: request issued, response due next cycle
  always_ff @(posedge CLOCK_50) begin
    if (imem_req) pc_p0 <= fetch_pc;
  end

  // p1: response registered into IR_out, or held while stalled
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      vld_p0   <= 1'b0;
      IR_out   <= BUBBLE_WORD;
      PC_out   <= RESET_PC + PC_OFF;
      ir_valid <= 1'b0;
    end else if (branch_en) begin
      fetch_pc <= branch_target & ~ADDR_W'(3);
      vld_p0   <= 1'b0;
      IR_out   <= BUBBLE_WORD;
      ir_valid <= 1'b0;
    end else begin
      vld_p0 <= imem_req;
      if (imem_req) fetch_pc <= fetch_pc + ADDR_W'(4);
      if (!stall) begin
        if (skid_full) begin
          IR_out   <= skid_data;
          PC_out   <= skid_pc;
          ir_valid <= 1'b1;
        end else if (vld_p0) begin
          IR_out   <= imem_rdata;
          PC_out   <= pc_vis_p0;
          ir_valid <= 1'b1;
        end else begin
          IR_out   <= BUBBLE_WORD;
          ir_valid <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (ir_valid && !stall) fetch_cnt <= fetch_cnt + 32'd1;
      if (branch_en) flush_cnt <= flush_cnt + 32'(vld_p0) + 32'(skid_full);
    end
  end
`else
  // counters not built
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scenario bench for fetch_unit: memory model returns 0xE2800000 + addr/4, expected
// deliveries are queued per scenario and popped whenever IR_out is consumed.
module tb_fetch_unit;

  localparam logic [31:0] BUBBLE = 32'hE100_0000;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_en = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] IR_out;
  logic [31:0] PC_out;
  logic        ir_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_deliv = 0;
  int   n_flush = 0;

  fetch_unit dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .IR_out        (IR_out),
    .PC_out        (PC_out),
    .ir_valid      (ir_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hE280_0000 + (a >> 2);
  endfunction

  always @(posedge CLOCK_50) begin
    if (imem_req) imem_rdata <= word_at(imem_addr);
  end

  task automatic expect_word(input logic [31:0] addr);
    exp_t e;
    e.ir = word_at(addr);
    e.pc = addr + 32'd8;
    sb.push_back(e);
  endtask

  // Sample at the falling edge; a consumed instruction is scored against the queue.
  task automatic half();
    exp_t e;
    @(negedge CLOCK_50);
    if (ir_valid === 1'b1 && !stall) begin
      checks++;
      n_deliv++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: IR_out=%h PC_out=%h delivered, nothing expected", IR_out, PC_out);
      end else begin
        e = sb.pop_front();
        if (IR_out !== e.ir || PC_out !== e.pc) begin
          errors++;
          $display("FAIL sb_order: IR_out=%h PC_out=%h, expected %h / %h", IR_out, PC_out, e.ir, e.pc);
        end
      end
    end
  endtask

  task automatic nxt();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic tick();
    half();
    nxt();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) nxt();
    reset = 1'b0;
    half();
    checks++;
    if (imem_req !== 1'b0 || ir_valid !== 1'b0 || IR_out !== BUBBLE || PC_out !== 32'd8 || imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: req=%b vld=%b IR=%h PC=%h addr=%h, expected 0 0 %h 00000008 00000000",
               imem_req, ir_valid, IR_out, PC_out, imem_addr, BUBBLE);
    end
    nxt();
  endtask

  task automatic test_stream();
    for (int a = 0; a < 5; a++) expect_word(32'(4 * a));
    for (int i = 1; i <= 7; i++) begin
      half();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (i - 1))) begin
        errors++;
        $display("FAIL stream_req: cycle %0d req=%b addr=%h, expected 1 %h", i, imem_req, imem_addr, 32'(4 * (i - 1)));
      end
      if (i < 3) begin
        checks++;
        if (ir_valid !== 1'b0) begin
          errors++;
          $display("FAIL stream_early: cycle %0d ir_valid=%b, expected 0", i, ir_valid);
        end
      end
      if (i == 3) begin
        checks++;
        if (ir_valid !== 1'b1 || IR_out !== 32'hE280_0000 || PC_out !== 32'd8) begin
          errors++;
          $display("FAIL stream_latency: vld=%b IR=%h PC=%h, expected 1 e2800000 00000008", ir_valid, IR_out, PC_out);
        end
      end
      nxt();
    end
  endtask

  task automatic test_stall();
    for (int a = 5; a <= 8; a++) expect_word(32'(4 * a));
    stall = 1'b1;
    for (int j = 0; j < 3; j++) begin
      half();
      checks++;
      if (imem_req !== 1'b0 || ir_valid !== 1'b1 || IR_out !== word_at(32'd20)) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d req=%b vld=%b IR=%h, expected 0 1 %h", j, imem_req, ir_valid, IR_out, word_at(32'd20));
      end
      nxt();
    end
    stall = 1'b0;
    half();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd28) begin
      errors++;
      $display("FAIL stall_resume: req=%b addr=%h, expected 1 0000001c", imem_req, imem_addr);
    end
    nxt();
    half();
    checks++;
    if (imem_addr !== 32'd32) begin
      errors++;
      $display("FAIL stall_next_addr: addr=%h, expected 00000020", imem_addr);
    end
    nxt();
    tick();
    tick();
  endtask

  task automatic test_reset_midstream();
    expect_word(32'd36);
    reset = 1'b1;
    half();
    nxt();
    reset = 1'b0;
    n_deliv = 0;
    for (int a = 0; a < 3; a++) expect_word(32'(4 * a));
    half();
    checks++;
    if (imem_req !== 1'b0 || ir_valid !== 1'b0 || IR_out !== BUBBLE || PC_out !== 32'd8 || imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL midreset_values: req=%b vld=%b IR=%h PC=%h addr=%h, expected 0 0 %h 00000008 00000000",
               imem_req, ir_valid, IR_out, PC_out, imem_addr, BUBBLE);
    end
    nxt();
    half();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_restart: req=%b addr=%h vld=%b, expected 1 00000000 0", imem_req, imem_addr, ir_valid);
    end
    nxt();
    half();
    checks++;
    if (ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_stale: ir_valid=%b IR=%h, expected 0", ir_valid, IR_out);
    end
    nxt();
    tick();
    tick();
  endtask

  task automatic test_branch();
    branch_en = 1'b1;
    branch_target = 32'h0000_0100;
    half();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL branch_req_block: req=%b, expected 0", imem_req);
    end
    nxt();
    branch_en = 1'b0;
    n_flush++;
    for (int a = 0; a < 3; a++) expect_word(32'h100 + 32'(4 * a));
    half();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_redirect: req=%b addr=%h vld=%b, expected 1 00000100 0", imem_req, imem_addr, ir_valid);
    end
    nxt();
    half();
    checks++;
    if (ir_valid !== 1'b0 || imem_addr !== 32'h104) begin
      errors++;
      $display("FAIL branch_gap: vld=%b addr=%h, expected 0 00000104", ir_valid, imem_addr);
    end
    nxt();
    half();
    checks++;
    if (ir_valid !== 1'b1 || IR_out !== word_at(32'h100) || PC_out !== 32'h108) begin
      errors++;
      $display("FAIL branch_target_word: vld=%b IR=%h PC=%h, expected 1 %h 00000108", ir_valid, IR_out, PC_out, word_at(32'h100));
    end
    nxt();
    tick();
    tick();
  endtask

  task automatic test_branch_stall();
    stall = 1'b1;
    half();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL bstall_req: req=%b, expected 0", imem_req);
    end
    nxt();
    branch_en = 1'b1;
    branch_target = 32'h0000_0202;
    tick();
    branch_en = 1'b0;
    n_flush++;
    half();
    checks++;
    if (ir_valid !== 1'b0 || imem_req !== 1'b0 || IR_out !== BUBBLE) begin
      errors++;
      $display("FAIL bstall_flush: vld=%b req=%b IR=%h, expected 0 0 %h", ir_valid, imem_req, IR_out, BUBBLE);
    end
    nxt();
    stall = 1'b0;
    expect_word(32'h200);
    expect_word(32'h204);
    half();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL bstall_target: req=%b addr=%h vld=%b, expected 1 00000200 0", imem_req, imem_addr, ir_valid);
    end
    nxt();
    half();
    checks++;
    if (ir_valid !== 1'b0 || imem_addr !== 32'h204) begin
      errors++;
      $display("FAIL bstall_gap: vld=%b addr=%h, expected 0 00000204", ir_valid, imem_addr);
    end
    nxt();
    half();
    checks++;
    if (IR_out !== word_at(32'h200) || PC_out !== 32'h208) begin
      errors++;
      $display("FAIL bstall_word: IR=%h PC=%h, expected %h 00000208", IR_out, PC_out, word_at(32'h200));
    end
    nxt();
  endtask

  task automatic test_wrap();
    branch_en = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    half();
    nxt();
    branch_en = 1'b0;
    n_flush++;
    expect_word(32'hFFFF_FFFC);
    expect_word(32'h0000_0000);
    half();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_top: req=%b addr=%h, expected 1 fffffffc", imem_req, imem_addr);
    end
    nxt();
    half();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_zero: req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
    end
    nxt();
    half();
    checks++;
    if (IR_out !== word_at(32'hFFFF_FFFC) || PC_out !== 32'h4) begin
      errors++;
      $display("FAIL wrap_pc_out: IR=%h PC=%h, expected %h 00000004", IR_out, PC_out, word_at(32'hFFFF_FFFC));
    end
    nxt();
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (fetch_cnt !== 32'(n_deliv) || flush_cnt !== 32'(n_flush)) begin
      errors++;
      $display("FAIL perf_counters: fetch_cnt=%0d flush_cnt=%0d, expected %0d %0d", fetch_cnt, flush_cnt, n_deliv, n_flush);
    end
`endif
    half();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d instructions never delivered, expected 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_reset_midstream();
    test_branch();
    test_branch_stall();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
